// File: rtl/radio_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : radio_seq_pkg
// Description : Shared types and constants for the radio enable sequencer.
//               Holds the per-channel FSM state encoding and the minimum
//               ramp/settle count applied when a programmed count is zero.
// Revision    : 1.0 - initial release
// ============================================================================
package radio_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RAMP   = 2'd1,
        RX     = 2'd2,
        SETTLE = 2'd3
    } radio_seq_state_e;

    // A programmed count of zero still spends one cycle in RAMP/SETTLE.
    localparam int RADIO_SEQ_MIN_CNT = 1;

endpackage : radio_seq_pkg
`default_nettype wire

// File: rtl/radio_seq_chan.sv
`default_nettype none
// ============================================================================
// Module      : radio_seq_chan
// Description : One radio channel sequencer: IDLE -> RAMP -> RX -> SETTLE.
//               All outputs are registered alongside the state.
// Ports       : ck, arst            clock / async active-high reset
//               i_req_rx, i_req_off single-cycle start / stop requests
//               i_ramp_cycles       enable-to-rx_en delay (sampled at load)
//               i_settle_cycles     rx_en-off-to-enable-off delay
//               o_enable, o_rx_en   pre-clamp radio enables
//               o_busy              state is not IDLE
//               o_err_req           one-cycle pulse for a rejected request
// Revision    : 1.0 - initial release
// ============================================================================
module radio_seq_chan
    import radio_seq_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             ck,
    input  logic             arst,
    input  logic             i_req_rx,
    input  logic             i_req_off,
    input  logic [CNT_W-1:0] i_ramp_cycles,
    input  logic [CNT_W-1:0] i_settle_cycles,
    output logic             o_enable,
    output logic             o_rx_en,
    output logic             o_busy,
    output logic             o_err_req
);

    localparam logic [CNT_W-1:0] c_min_cnt = CNT_W'(RADIO_SEQ_MIN_CNT);

    radio_seq_state_e r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_enable;
    logic             r_rx_en;
    logic             r_busy;
    logic             r_err;

    logic [CNT_W-1:0] w_ramp_load;
    logic [CNT_W-1:0] w_settle_load;

    // Counts are clamped to at least one cycle at load time only.
    assign w_ramp_load   = (i_ramp_cycles   < c_min_cnt) ? c_min_cnt : i_ramp_cycles;
    assign w_settle_load = (i_settle_cycles < c_min_cnt) ? c_min_cnt : i_settle_cycles;

    always_ff @(posedge ck or posedge arst) begin
        if (arst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_enable <= 1'b0;
            r_rx_en  <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            // Any start request outside IDLE is rejected, whatever else happens.
            r_err <= i_req_rx && (r_state != IDLE);

            case (r_state)
                IDLE: begin
                    // A stop in the same cycle cancels the start silently.
                    if (i_req_rx && !i_req_off) begin
                        r_state  <= RAMP;
                        r_cnt    <= w_ramp_load;
                        r_enable <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                RAMP: begin
                    // Abort takes priority over ramp completion.
                    if (i_req_off) begin
                        r_state <= SETTLE;
                        r_cnt   <= w_settle_load;
                    end else if (r_cnt <= c_min_cnt) begin
                        r_state <= RX;
                        r_cnt   <= '0;
                        r_rx_en <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RX: begin
                    if (i_req_off) begin
                        r_state <= SETTLE;
                        r_cnt   <= w_settle_load;
                        r_rx_en <= 1'b0;
                    end
                end
                SETTLE: begin
                    // Requests are ignored here; the count is never reloaded.
                    if (r_cnt <= c_min_cnt) begin
                        r_state  <= IDLE;
                        r_cnt    <= '0;
                        r_enable <= 1'b0;
                        r_busy   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_cnt    <= '0;
                    r_enable <= 1'b0;
                    r_rx_en  <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign o_enable  = r_enable;
    assign o_rx_en   = r_rx_en;
    assign o_busy    = r_busy;
    assign o_err_req = r_err;

endmodule : radio_seq_chan
`default_nettype wire

// File: rtl/radio_enable_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : radio_enable_sequencer
// Description : BIT_WIDTH independent radio power-up/receive sequencers with
//               an isolation clamp on the radio outputs for the power-gated
//               boundary. The clamp is the only combinational output path.
// Ports       : ck, arst                    clock / async active-high reset
//               isolate                     force radio outputs to 0
//               req_rx, req_off             per-channel start / stop pulses
//               ramp_cycles, settle_cycles  shared delay programming
//               radio_enable, radio_rx_en   clamped radio enables
//               busy, err_req               per-channel status (unclamped)
// Revision    : 1.0 - initial release
// ============================================================================
module radio_enable_sequencer #(
    parameter int BIT_WIDTH = 2,
    parameter int CNT_W     = 8
) (
    input  logic                 ck,
    input  logic                 arst,
    input  logic                 isolate,
    input  logic [BIT_WIDTH-1:0] req_rx,
    input  logic [BIT_WIDTH-1:0] req_off,
    input  logic [CNT_W-1:0]     ramp_cycles,
    input  logic [CNT_W-1:0]     settle_cycles,
    output logic [BIT_WIDTH-1:0] radio_enable,
    output logic [BIT_WIDTH-1:0] radio_rx_en,
    output logic [BIT_WIDTH-1:0] busy,
    output logic [BIT_WIDTH-1:0] err_req
);

    logic [BIT_WIDTH-1:0] w_enable;
    logic [BIT_WIDTH-1:0] w_rx_en;

    generate
        for (genvar g = 0; g < BIT_WIDTH; g++) begin : g_chan
            radio_seq_chan #(
                .CNT_W (CNT_W)
            ) u_chan (
                .ck              (ck),
                .arst            (arst),
                .i_req_rx        (req_rx[g]),
                .i_req_off       (req_off[g]),
                .i_ramp_cycles   (ramp_cycles),
                .i_settle_cycles (settle_cycles),
                .o_enable        (w_enable[g]),
                .o_rx_en         (w_rx_en[g]),
                .o_busy          (busy[g]),
                .o_err_req       (err_req[g])
            );
        end
    endgenerate

    // Sequencers keep running while isolated; only the radio pins are forced low.
    assign radio_enable = w_enable & ~{BIT_WIDTH{isolate}};
    assign radio_rx_en  = w_rx_en  & ~{BIT_WIDTH{isolate}};

endmodule : radio_enable_sequencer
`default_nettype wire

// File: tb/tb_radio_enable_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_radio_enable_sequencer
// Description : Self-checking bench for radio_enable_sequencer. A timestamp
//               reference model predicts, per channel, the cycles at which
//               enable and rx_en rise and fall, plus expected error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_radio_enable_sequencer;

    localparam int     NCH = 2;
    localparam longint INF = 64'sh3fff_ffff_ffff_ffff;

    logic           ck = 1'b0;
    logic           arst;
    logic           isolate;
    logic [NCH-1:0] req_rx;
    logic [NCH-1:0] req_off;
    logic [7:0]     ramp_cycles;
    logic [7:0]     settle_cycles;
    logic [NCH-1:0] radio_enable;
    logic [NCH-1:0] radio_rx_en;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] err_req;

    int     checks   = 0;
    int     failures = 0;
    longint cyc      = 0;

    // Model: cycle windows [t_start, t_end) busy, [t_rx, t_rxend) receiving.
    longint t_start [NCH];
    longint t_end   [NCH];
    longint t_rx    [NCH];
    longint t_rxend [NCH];
    longint err_at  [NCH];

    radio_enable_sequencer #(
        .BIT_WIDTH (NCH),
        .CNT_W     (8)
    ) dut (
        .ck            (ck),
        .arst          (arst),
        .isolate       (isolate),
        .req_rx        (req_rx),
        .req_off       (req_off),
        .ramp_cycles   (ramp_cycles),
        .settle_cycles (settle_cycles),
        .radio_enable  (radio_enable),
        .radio_rx_en   (radio_rx_en),
        .busy          (busy),
        .err_req       (err_req)
    );

    always #5 ck = ~ck;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic m_busy(input int i, input longint c);
        return (c >= t_start[i]) && (c < t_end[i]);
    endfunction

    function automatic logic m_rx(input int i, input longint c);
        return (c >= t_rx[i]) && (c < t_rxend[i]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            t_start[i] = INF; t_end[i] = INF;
            t_rx[i]    = INF; t_rxend[i] = INF;
            err_at[i]  = -1;
        end
    endtask

    // Apply the requests sampled at the end of cycle c.
    task automatic model_update(input longint c, input logic [NCH-1:0] rx,
                                input logic [NCH-1:0] off, input int r_raw, input int s_raw);
        longint r_eff;
        longint s_eff;
        r_eff = (r_raw < 1) ? 1 : r_raw;
        s_eff = (s_raw < 1) ? 1 : s_raw;
        for (int i = 0; i < NCH; i++) begin
            if (!m_busy(i, c)) begin
                if (rx[i] && !off[i]) begin
                    t_start[i] = c + 1;
                    t_end[i]   = INF;
                    t_rx[i]    = c + 1 + r_eff;
                    t_rxend[i] = INF;
                end
            end else begin
                if (rx[i]) err_at[i] = c + 1;
                // Stop only matters before the settle window is scheduled.
                if (off[i] && t_end[i] == INF) begin
                    if (c < t_rx[i]) t_rx[i] = INF;
                    else             t_rxend[i] = c + 1;
                    t_end[i] = c + 1 + s_eff;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < NCH; i++) begin
            chk($sformatf("en%0d", i),   32'(radio_enable[i]), 32'(m_busy(i, cyc) & ~isolate));
            chk($sformatf("rx%0d", i),   32'(radio_rx_en[i]),  32'(m_rx(i, cyc) & ~isolate));
            chk($sformatf("busy%0d", i), 32'(busy[i]),         32'(m_busy(i, cyc)));
            chk($sformatf("err%0d", i),  32'(err_req[i]),      32'(err_at[i] == cyc));
        end
        chk("inv_rx_implies_en", 32'(radio_rx_en & ~radio_enable), 32'd0);
    endtask

    // Drive one cycle of inputs from a negedge, then check the next cycle.
    task automatic step(input logic [NCH-1:0] rx, input logic [NCH-1:0] off, input logic iso);
        req_rx  = rx;
        req_off = off;
        isolate = iso;
        model_update(cyc, rx, off, int'(ramp_cycles), int'(settle_cycles));
        @(posedge ck);
        cyc++;
        @(negedge ck);
        compare_all();
    endtask

    task automatic idle_steps(input int n, input logic iso);
        for (int k = 0; k < n; k++) step('0, '0, iso);
    endtask

    task automatic pulse_reset();
        arst = 1'b1;
        #1;
        chk("arst_en",   32'(radio_enable), 32'd0);
        chk("arst_rx",   32'(radio_rx_en),  32'd0);
        chk("arst_busy", 32'(busy),         32'd0);
        model_reset();
        @(posedge ck);
        cyc++;
        @(negedge ck);
        arst = 1'b0;
        compare_all();
    endtask

    initial begin
        arst          = 1'b1;
        isolate       = 1'b0;
        req_rx        = '0;
        req_off       = '0;
        ramp_cycles   = 8'd3;
        settle_cycles = 8'd2;
        model_reset();
        @(negedge ck);
        chk("reset_en",   32'(radio_enable), 32'd0);
        chk("reset_rx",   32'(radio_rx_en),  32'd0);
        chk("reset_busy", 32'(busy),         32'd0);
        chk("reset_err",  32'(err_req),      32'd0);
        arst = 1'b0;
        idle_steps(3, 1'b0);

        // Basic sequence, ramp=3 settle=2.
        step(2'b01, 2'b00, 1'b0);
        chk("basic_en_rise", 32'(radio_enable), 32'd1);
        chk("basic_rx_low",  32'(radio_rx_en),  32'd0);
        idle_steps(2, 1'b0);
        chk("basic_rx_still_low", 32'(radio_rx_en), 32'd0);
        step(2'b00, 2'b00, 1'b0);
        chk("basic_rx_rise", 32'(radio_rx_en), 32'd1);
        idle_steps(5, 1'b0);
        step(2'b00, 2'b01, 1'b0);
        chk("basic_rx_fall",   32'(radio_rx_en),  32'd0);
        chk("basic_en_settle", 32'(radio_enable), 32'd1);
        step(2'b00, 2'b00, 1'b0);
        chk("basic_busy_settle", 32'(busy), 32'd1);
        step(2'b00, 2'b00, 1'b0);
        chk("basic_en_fall",   32'(radio_enable), 32'd0);
        chk("basic_busy_fall", 32'(busy),         32'd0);
        idle_steps(2, 1'b0);

        // Zero counts behave as one cycle.
        ramp_cycles   = 8'd0;
        settle_cycles = 8'd0;
        step(2'b01, 2'b00, 1'b0);
        chk("zero_rx_low", 32'(radio_rx_en), 32'd0);
        step(2'b00, 2'b00, 1'b0);
        chk("zero_rx_rise", 32'(radio_rx_en), 32'd1);
        step(2'b00, 2'b01, 1'b0);
        chk("zero_en_hold", 32'(radio_enable), 32'd1);
        step(2'b00, 2'b00, 1'b0);
        chk("zero_en_fall", 32'(radio_enable), 32'd0);
        idle_steps(2, 1'b0);

        // Abort in RAMP, start request during RX, simultaneous requests in IDLE.
        ramp_cycles   = 8'd4;
        settle_cycles = 8'd3;
        step(2'b01, 2'b00, 1'b0);
        step(2'b00, 2'b01, 1'b0);
        idle_steps(6, 1'b0);
        step(2'b10, 2'b00, 1'b0);
        idle_steps(5, 1'b0);
        step(2'b10, 2'b00, 1'b0);
        chk("err_pulse", 32'(err_req), 32'd2);
        step(2'b00, 2'b00, 1'b0);
        chk("err_one_cycle", 32'(err_req), 32'd0);
        chk("err_rx_kept",   32'(radio_rx_en), 32'd2);
        step(2'b11, 2'b11, 1'b0);
        step(2'b10, 2'b00, 1'b0);
        idle_steps(5, 1'b0);
        chk("simul_idle_quiet", 32'(busy), 32'd0);

        // Isolation mid-RX on channel 0.
        ramp_cycles = 8'd1;
        step(2'b01, 2'b00, 1'b0);
        idle_steps(2, 1'b0);
        idle_steps(3, 1'b1);
        chk("iso_clamped", 32'(radio_enable | radio_rx_en), 32'd0);
        chk("iso_busy",    32'(busy), 32'd1);
        idle_steps(2, 1'b0);
        chk("iso_release", 32'(radio_rx_en), 32'd1);
        step(2'b00, 2'b01, 1'b0);
        idle_steps(4, 1'b0);

        // Reset mid-RAMP, then nominal restart.
        ramp_cycles = 8'd5;
        step(2'b01, 2'b00, 1'b0);
        idle_steps(2, 1'b0);
        pulse_reset();
        idle_steps(1, 1'b0);
        step(2'b01, 2'b00, 1'b0);
        idle_steps(4, 1'b0);
        chk("rst_restart_rx_low", 32'(radio_rx_en), 32'd0);
        step(2'b00, 2'b00, 1'b0);
        chk("rst_restart_rx", 32'(radio_rx_en), 32'd1);
        step(2'b00, 2'b01, 1'b0);
        idle_steps(4, 1'b0);

        // Staggered channels with ramp change during an active count.
        ramp_cycles = 8'd6;
        step(2'b01, 2'b00, 1'b0);
        ramp_cycles = 8'd1;
        step(2'b00, 2'b00, 1'b0);
        step(2'b10, 2'b00, 1'b0);
        idle_steps(6, 1'b0);
        step(2'b00, 2'b11, 1'b0);
        idle_steps(4, 1'b0);

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [NCH-1:0] rx;
            logic [NCH-1:0] off;
            logic           iso;
            if ($urandom_range(0, 15) == 0) ramp_cycles   = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 15) == 0) settle_cycles = 8'($urandom_range(0, 5));
            for (int i = 0; i < NCH; i++) begin
                rx[i]  = ($urandom_range(0, 7) == 0);
                off[i] = ($urandom_range(0, 9) == 0);
            end
            iso = ($urandom_range(0, 19) == 0);
            step(rx, off, iso);
            if ($urandom_range(0, 499) == 0) pulse_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_radio_enable_sequencer
`default_nettype wire

// File: doc/radio_enable_sequencer.md
# radio_enable_sequencer

Per-channel radio power-up/receive sequencer feeding the TimingEngine radio-enable path: it produces the `radioEnable`/`radioRxEn` bit vectors that the downstream stages synchronise and register. On request, each channel raises its enable, waits a programmable ramp time, raises receive-enable, then on release drops receive-enable and holds enable for a programmable settle time before powering down. Outputs pass through an isolation clamp for the power-gated M1/M2 boundary.

## Interface
- `BIT_WIDTH`, default 2: number of independent radio channels.
- `CNT_W`, default 8: width of ramp/settle counters.

- `ck`  in  1  clock, rising edge.
- `arst`  in  1  reset, asynchronous, active-high.
- `isolate`  in  1  when 1, all radio outputs clamped to 0; FSMs keep running.
- `req_rx`  in  BIT_WIDTH  per-channel single-cycle request to start receive.
- `req_off`  in  BIT_WIDTH  per-channel single-cycle request to stop.
- `ramp_cycles`  in  CNT_W  enable-to-rxEn delay, shared by all channels.
- `settle_cycles`  in  CNT_W  rxEn-off-to-enable-off delay, shared.
- `radio_enable`  out  BIT_WIDTH  radio power enable per channel.
- `radio_rx_en`  out  BIT_WIDTH  radio receive enable per channel.
- `busy`  out  BIT_WIDTH  channel not in IDLE.
- `err_req`  out  BIT_WIDTH  one-cycle pulse: `req_rx` rejected.

## Operation
- Per-channel FSM: IDLE, RAMP, RX, SETTLE. Channels are fully independent.
- IDLE: enable=0, rx_en=0. `req_rx` → RAMP; load counter with R = max(`ramp_cycles`,1).
- RAMP: enable=1, rx_en=0. Counter decrements each cycle; the transition to RX occurs once R cycles have been spent in RAMP. `req_off` → SETTLE (abort; rx_en never asserts).
- RX: enable=1, rx_en=1. Stays until `req_off` → SETTLE; load counter with S = max(`settle_cycles`,1).
- SETTLE: enable=1, rx_en=0. After S cycles in SETTLE → IDLE.
- `ramp_cycles`/`settle_cycles` are sampled only at counter load; later changes do not affect an active count.
- `req_rx` outside IDLE: ignored, `err_req` pulses the next cycle.
- `req_rx` and `req_off` in the same cycle: `req_off` wins. In IDLE the channel stays in IDLE with no error. In RAMP/RX it goes to SETTLE and `err_req` pulses. In SETTLE it keeps settling (the counter is not reloaded) and `err_req` pulses.
- `req_off` in IDLE or SETTLE: ignored, no error.
- `busy` = state ≠ IDLE, registered with state.
- Isolation: `radio_enable`/`radio_rx_en` = registered value AND NOT `isolate` (combinational clamp). `busy` and `err_req` are not clamped.
- Invariant: `radio_rx_en[i]`=1 implies `radio_enable[i]`=1 (pre-clamp).

## Timing
- Reset: all channels IDLE. All outputs are 0, and counters are 0.
- `arst` mid-sequence drops enable and rx_en asynchronously. There is no settle phase.
- `req_rx` sampled at edge t: `radio_enable` = 1 from t+1, and `radio_rx_en` = 1 from t+1+R.
- `req_off` sampled at edge u in RX: `radio_rx_en` = 0 from u+1, and `radio_enable` = 0 from u+1+S. The channel is back in IDLE at u+1+S, so a new `req_rx` is accepted at that edge.
- `err_req` is asserted for exactly one cycle, at t+1 after the offending edge.
- All outputs except the isolation clamp are registered. No combinational path runs from the `req_*` inputs to the outputs.

## Structure
- Package `radio_seq_pkg`: `radio_seq_state_e` enum (IDLE, RAMP, RX, SETTLE) and a `RADIO_SEQ_MIN_CNT` = 1 constant.
- Sub-module `radio_seq_chan`: one FSM plus counter. It is instantiated BIT_WIDTH times in a generate loop.
- The isolation clamp lives in the top level.

## Test plan
- Basic sequence: ramp=3, settle=2, `req_rx[0]` at t=10.
  - Enable rises at 11 and rx_en at 14.
  - `req_off[0]` at 20 → rx_en falls at 21 and enable falls at 23.
  - `busy[0]` is high for 11..22.
  - Channel 1 stays 0 throughout.
- Zero counts: ramp=0, settle=0.
  - rx_en lags enable by exactly 1 cycle, and enable lags rx_en-off by exactly 1 cycle.
- Abort and errors:
  - `req_off` during RAMP → rx_en never rises; enable falls S cycles later.
  - `req_rx` during RX → `err_req` is a 1-cycle pulse and the state is unchanged.
  - Simultaneous `req_rx`+`req_off` in IDLE → no activity and no error.
- Isolation: `isolate`=1 mid-RX.
  - Both outputs read 0 while `busy` stays 1.
  - Deassert `isolate` → outputs return to 1 with no glitch through IDLE.
- Reset mid-RAMP: `arst` pulse.
  - All outputs are 0 immediately.
  - After release, a `req_rx` restarts the sequence with the nominal R latency.
- Independence:
  - Both channels run with staggered requests; changing `ramp_cycles` mid-count changes only later loads.
  - The invariant rx_en ⇒ enable is checked by an assertion every cycle.
